shift_seq8: RTL

- Multi-cycle 8-bit shift unit that drives the team's 8-bit combinational shift stage, which accepts a 2-bit shift amount (0..3).
- Accepts a 3-bit shift amount (0..7) and an operation, then performs it in steps of at most 3 bits per clock.
- An internal remaining-count counter and a 3-state FSM control the steps.
- Result and a one-cycle done pulse go to the downstream consumer; start/busy form the upstream handshake.

---
 rtl/shift_seq8.sv | 135 +++++++++++++
 1 files changed

// File: rtl/shift_seq8.sv
// shift_seq8: multi-cycle 8-bit shifter that reaches amounts up to 7
// by driving a 0..3 combinational shift stage once per clock.

module shift_stage8 (
    input  logic [7:0] data,
    input  logic [1:0] op,
    input  logic [1:0] amt,
    output logic [7:0] result
);

    logic [15:0] rot;

    assign rot = {data, data} >> amt;

    // One combinational step: op applied by 0..3 bit positions
    always_comb begin
        result = data;
        unique case (1'b1)
            (op == 2'b00): result = data << amt;
            (op == 2'b01): result = data >> amt;
            (op == 2'b10): result = $unsigned($signed(data) >>> amt);
            (op == 2'b11): result = rot[7:0];
            default:       result = data;
        endcase
    end

endmodule

module shift_seq8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] d_in,
    input  logic [2:0] shamt,
    output logic [7:0] d_out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] data_q;
    logic [2:0] rem_q;
    logic [1:0] op_q;
    logic [1:0] step;
    logic [2:0] rem_next;
    logic [7:0] stage_out;
    logic       load;
    logic       advance;

    // Step is the remaining count clamped to what the stage can do
    always_comb begin
        step = 2'd3;
        if (rem_q < 3'd3) begin
            step = rem_q[1:0];
        end
    end

    assign rem_next = rem_q - {1'b0, step};

    shift_stage8 u_stage (
        .data   (data_q),
        .op     (op_q),
        .amt    (step),
        .result (stage_out)
    );

    // Next-state decode and load/advance strobes
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        unique case (1'b1)
            (state_q == IDLE): begin
                if (start) begin
                    load = 1'b1;
                    if (shamt == 3'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            (state_q == SHIFT): begin
                advance = 1'b1;
                if (rem_next == 3'd0) begin
                    state_d = DONE;
                end
            end
            (state_q == DONE): begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: load operands on accept, shift one step per SHIFT cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= 8'h00;
            rem_q  <= 3'd0;
            op_q   <= 2'b00;
        end else if (load) begin
            data_q <= d_in;
            rem_q  <= shamt;
            op_q   <= op;
        end else if (advance) begin
            data_q <= stage_out;
            rem_q  <= rem_next;
        end
    end

    assign d_out = data_q;
    assign busy  = (state_q == SHIFT);
    assign done  = (state_q == DONE);

endmodule
